// File: rtl/vm_decoder_2to4.sv
// Registered 2-to-4 one-hot decoder with capture enable, valid flag,
// selection-change strobe and a saturating hold counter.
module vm_decoder_2to4 #(
    parameter logic        ACTIVE_LOW = 1'b0,
    parameter int unsigned HOLD_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              sel0,
    input  logic              sel1,
    output logic              S0,
    output logic              S1,
    output logic              S2,
    output logic              S3,
    output logic              valid,
    output logic              changed,
    output logic [HOLD_W-1:0] hold_cnt
);

    logic [1:0]        w_idx;
    logic              w_diff;
    logic              w_hold_max;
    logic [3:0]        w_onehot_next;

    logic [3:0]        r_onehot;
    logic [1:0]        r_last_idx;
    logic              r_valid;
    logic              r_changed;
    logic [HOLD_W-1:0] r_hold;

    assign w_idx      = {sel1, sel0};
    // The first capture after reset always counts as a change.
    assign w_diff     = !r_valid || (w_idx != r_last_idx);
    assign w_hold_max = &r_hold;

    always_comb begin
        w_onehot_next        = '0;
        w_onehot_next[w_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_onehot   <= '0;
            r_last_idx <= '0;
            r_valid    <= 1'b0;
            r_changed  <= 1'b0;
            r_hold     <= '0;
        end else if (en) begin
            r_onehot   <= w_onehot_next;
            r_last_idx <= w_idx;
            r_valid    <= 1'b1;
            r_changed  <= w_diff;
            if (w_diff) begin
                r_hold <= '0;
            end else if (!w_hold_max) begin
                r_hold <= r_hold + 1'b1;
            end
        end else begin
            r_changed  <= 1'b0;
        end
    end

    // Polarity is applied to the registered one-hot, so no input-to-output path exists.
    assign S0       = r_onehot[0] ^ ACTIVE_LOW;
    assign S1       = r_onehot[1] ^ ACTIVE_LOW;
    assign S2       = r_onehot[2] ^ ACTIVE_LOW;
    assign S3       = r_onehot[3] ^ ACTIVE_LOW;
    assign valid    = r_valid;
    assign changed  = r_changed;
    assign hold_cnt = r_hold;

endmodule

// File: tb/tb_vm_decoder_2to4.sv
// Randomised and directed bench for vm_decoder_2to4: two instances (active-high,
// HOLD_W=8 and active-low, HOLD_W=3) checked every cycle against a behavioural model.
module tb_vm_decoder_2to4;

    logic clk = 1'b0;
    logic rst, en, sel0, sel1;

    logic       a_S0, a_S1, a_S2, a_S3, a_valid, a_changed;
    logic [7:0] a_hold;
    logic       b_S0, b_S1, b_S2, b_S3, b_valid, b_changed;
    logic [2:0] b_hold;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Behavioural model state: index 0 -> instance a, index 1 -> instance b
    int m_valid [2];
    int m_last  [2];
    int m_hold  [2];
    int m_chg   [2];
    int m_max   [2] = '{255, 7};
    int m_al    [2] = '{0, 1};

    always #5 clk = ~clk;

    vm_decoder_2to4 #(.ACTIVE_LOW(1'b0), .HOLD_W(8)) dut_a (
        .clk(clk), .rst(rst), .en(en), .sel0(sel0), .sel1(sel1),
        .S0(a_S0), .S1(a_S1), .S2(a_S2), .S3(a_S3),
        .valid(a_valid), .changed(a_changed), .hold_cnt(a_hold)
    );

    vm_decoder_2to4 #(.ACTIVE_LOW(1'b1), .HOLD_W(3)) dut_b (
        .clk(clk), .rst(rst), .en(en), .sel0(sel0), .sel1(sel1),
        .S0(b_S0), .S1(b_S1), .S2(b_S2), .S3(b_S3),
        .valid(b_valid), .changed(b_changed), .hold_cnt(b_hold)
    );

    function automatic int vec_a();
        return int'({a_S3, a_S2, a_S1, a_S0});
    endfunction

    function automatic int vec_b();
        return int'({b_S3, b_S2, b_S1, b_S0});
    endfunction

    function automatic int exp_vec(int k);
        int v;
        v = (m_valid[k] != 0) ? (1 << m_last[k]) : 0;
        if (m_al[k] != 0) v = v ^ 15;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_valid[k] = 0; m_last[k] = 0; m_hold[k] = 0; m_chg[k] = 0;
            end else if (en) begin
                int idx;
                idx = 2 * int'(sel1) + int'(sel0);
                m_chg[k]  = (m_valid[k] == 0 || idx != m_last[k]) ? 1 : 0;
                m_hold[k] = (m_chg[k] != 0) ? 0
                          : ((m_hold[k] + 1 > m_max[k]) ? m_max[k] : m_hold[k] + 1);
                m_last[k]  = idx;
                m_valid[k] = 1;
            end else begin
                m_chg[k] = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("a_S",       vec_a(),          exp_vec(0));
            chk("a_valid",   int'(a_valid),    m_valid[0]);
            chk("a_changed", int'(a_changed),  m_chg[0]);
            chk("a_hold",    int'(a_hold),     m_hold[0]);
            chk("b_S",       vec_b(),          exp_vec(1));
            chk("b_valid",   int'(b_valid),    m_valid[1]);
            chk("b_changed", int'(b_changed),  m_chg[1]);
            chk("b_hold",    int'(b_hold),     m_hold[1]);
        end
    end

    task automatic set_sel(input int v);
        sel1 = v[1];
        sel0 = v[0];
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sel0 = 1'b0; sel1 = 1'b0;
        repeat (2) @(negedge clk);
        cmp_on = 1'b1;
        chk("lit_reset_a_S", vec_a(), 0);
        chk("lit_reset_b_S", vec_b(), 15);
        chk("lit_reset_valid", int'(a_valid), 0);
        chk("lit_reset_hold", int'(a_hold), 0);

        rst = 1'b0; en = 1'b1;
        for (int v = 0; v < 4; v++) begin
            set_sel(v);
            @(negedge clk);
            chk("lit_seg_changed", int'(a_changed), 1);
            repeat (9) @(negedge clk);
            chk("lit_seg_a_S", vec_a(), 1 << v);
            chk("lit_seg_b_S", vec_b(), 15 ^ (1 << v));
            chk("lit_seg_hold", int'(a_hold), 9);
            chk("lit_seg_b_hold", int'(b_hold), 7);
        end

        set_sel(2);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            set_sel(i % 4);
            @(negedge clk);
            chk("lit_hold_a_S", vec_a(), 4);
            chk("lit_hold_changed", int'(a_changed), 0);
        end

        en = 1'b1; set_sel(3);
        repeat (300) @(negedge clk);
        chk("lit_sat_hold", int'(a_hold), 255);
        @(negedge clk);
        chk("lit_sat_hold_stays", int'(a_hold), 255);

        set_sel(1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("lit_midrst_a_S", vec_a(), 0);
        chk("lit_midrst_b_S", vec_b(), 15);
        chk("lit_midrst_valid", int'(a_valid), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("lit_post_a_S", vec_a(), 2);
        chk("lit_post_changed", int'(a_changed), 1);
        chk("lit_post_hold", int'(a_hold), 0);

        for (int i = 0; i < 2000; i++) begin
            rst = ($urandom_range(31) == 0);
            en  = ($urandom_range(3) != 0);
            if ($urandom_range(2) == 0) set_sel(int'($urandom_range(3)));
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
